// File: rtl/s2mm_writer_pkg.sv
// Shared AXI constants, FSM state encoding and the AxSIZE helper for the stream-to-memory writer.
package s2mm_writer_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    S2MM_IDLE  = 3'b001,
    S2MM_ISSUE = 3'b010,
    S2MM_RESP  = 3'b100
  } s2mm_state_e;

  // AXI AxSIZE encoding is log2 of the bytes per beat.
  function automatic logic [2:0] axi_size(input int data_width);
    int bytes;
    logic [2:0] size;
    bytes = data_width / 8;
    size  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/s2mm_writer.sv
// Stream-to-memory writer: each accepted AXI4-Stream sample becomes one single-beat AXI4 write
// to the address sync_manager presents on write_buffer.
module s2mm_writer
  import s2mm_writer_pkg::*;
#(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [MM_ADDR_WIDTH-1:0] write_buffer,
  output logic                     reading,
  output logic                     writing,
  output logic [MM_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]               m_axi_awlen,
  output logic [2:0]               m_axi_awsize,
  output logic [1:0]               m_axi_awburst,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [DATA_WIDTH-1:0]    m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]  m_axi_wstrb,
  output logic                     m_axi_wlast,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic                     resp_error,
  output logic [15:0]              error_count,
  output logic [2:0]               debug_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1; a raised
  // valid holds, with its payload stable, until that edge; ready may change freely.

  localparam logic [2:0] AWSIZE = axi_size(DATA_WIDTH);

  s2mm_state_e state, state_next;
  logic        accept;
  logic        tready_next, awvalid_next, wvalid_next, bready_next, writing_next;
  logic        resp_bad;

  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AWSIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = 1'b1;
  assign debug_state   = state;

  // A reset cycle must never look like an acceptance to sync_manager.
  assign accept  = s_axis_tvalid & s_axis_tready & ~areset;
  assign reading = accept;

  always_comb begin
    state_next   = state;
    tready_next  = 1'b0;
    awvalid_next = m_axi_awvalid;
    wvalid_next  = m_axi_wvalid;
    bready_next  = m_axi_bready;
    writing_next = 1'b0;
    case (state)
      S2MM_IDLE: begin
        tready_next = ~accept;
        if (accept) begin
          awvalid_next = 1'b1;
          wvalid_next  = 1'b1;
          state_next   = S2MM_ISSUE;
        end
      end
      S2MM_ISSUE: begin
        if (m_axi_awready) awvalid_next = 1'b0;
        if (m_axi_wready)  wvalid_next  = 1'b0;
        if (!awvalid_next && !wvalid_next) begin
          bready_next = 1'b1;
          state_next  = S2MM_RESP;
        end
      end
      S2MM_RESP: begin
        if (m_axi_bvalid) begin
          bready_next  = 1'b0;
          writing_next = 1'b1;
          state_next   = S2MM_IDLE;
        end
      end
      default: state_next = S2MM_IDLE;
    endcase
  end

  assign resp_bad = writing_next && (m_axi_bresp != AXI_RESP_OKAY);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= S2MM_IDLE;
      s_axis_tready <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      writing       <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      resp_error    <= 1'b0;
      error_count   <= 16'd0;
    end else begin
      state         <= state_next;
      s_axis_tready <= tready_next;
      m_axi_awvalid <= awvalid_next;
      m_axi_wvalid  <= wvalid_next;
      m_axi_bready  <= bready_next;
      writing       <= writing_next;
      if (accept) begin
        m_axi_awaddr <= write_buffer;
        m_axi_wdata  <= s_axis_tdata;
      end
      if (resp_bad) begin
        resp_error <= 1'b1;
        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_s2mm_writer.sv
// Randomised bench for s2mm_writer: a transaction-level model with a responsive AXI slave,
// checking every cycle against an expected-write queue.
module tb_s2mm_writer;
  import s2mm_writer_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    int            aw_dly;
    int            w_dly;
    int            b_dly;
    logic [1:0]    resp;
    int            gap;
  } smp_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset = 1'b1;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [AW-1:0] write_buffer = '0;
  logic          reading, writing;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast, wvalid;
  logic          wready = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;
  logic          bready;
  logic          resp_error;
  logic [15:0]   error_count;
  logic [2:0]    debug_state;

  s2mm_writer #(.MM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .write_buffer(write_buffer), .reading(reading), .writing(writing),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .resp_error(resp_error), .error_count(error_count), .debug_state(debug_state)
  );

  // scoreboard and model state
  logic [AW+DW-1:0] exp_q[$];
  smp_t stim_q[$];
  smp_t cur;
  int   n_vec = 0, n_err = 0;
  int   n_read = 0, n_write = 0;
  int   cycle = 0, offer_at = 0;
  int   issue_age = 0, both_age = 0, ready_wait = 1;
  bit   outstanding = 0, aw_done = 0, w_done = 0, exp_writing = 0;
  bit   just_reset = 0, rst_req = 1;
  logic resp_err_m = 1'b0;
  logic [15:0] err_cnt_m = 16'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [2:0] exp_state();
    if (!outstanding) return S2MM_IDLE;
    return (aw_done && w_done) ? S2MM_RESP : S2MM_ISSUE;
  endfunction

  task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] a, input int awd,
                      input int wd, input int bd, input logic [1:0] r, input int g);
    smp_t s;
    s.data = d; s.addr = a; s.aw_dly = awd; s.w_dly = wd; s.b_dly = bd; s.resp = r; s.gap = g;
    stim_q.push_back(s);
  endtask

  // One clock: observe and check on the falling edge, then drive just after the rising edge.
  task automatic step();
    bit acc, awf, wf, bf;
    @(negedge clk);
    cycle++;
    if (areset) begin
      check("reading_in_reset", 64'(reading), 64'(0));
      outstanding = 0; aw_done = 0; w_done = 0; exp_writing = 0;
      ready_wait = 1; just_reset = 1; resp_err_m = 1'b0; err_cnt_m = 16'd0;
      exp_q.delete();
    end else begin
      acc = tvalid && tready;
      awf = awvalid && awready;
      wf  = wvalid && wready;
      bf  = bvalid && bready;
      check("state", 64'(debug_state), 64'(exp_state()));
      check("tready", 64'(tready), 64'(!outstanding && ready_wait == 0));
      check("reading", 64'(reading), 64'(acc));
      check("awvalid", 64'(awvalid), 64'(outstanding && !aw_done));
      check("wvalid", 64'(wvalid), 64'(outstanding && !w_done));
      check("bready", 64'(bready), 64'(outstanding && aw_done && w_done));
      check("writing", 64'(writing), 64'(exp_writing));
      check("resp_error", 64'(resp_error), 64'(resp_err_m));
      check("error_count", 64'(error_count), 64'(err_cnt_m));
      if (just_reset) begin
        check("reset_awaddr", 64'(awaddr), 64'(0));
        check("reset_wdata", 64'(wdata), 64'(0));
        just_reset = 0;
      end
      if (awvalid && exp_q.size() > 0) check("awaddr", 64'(awaddr), 64'(exp_q[0][AW+DW-1:DW]));
      if (wvalid && exp_q.size() > 0) check("wdata", 64'(wdata), 64'(exp_q[0][DW-1:0]));
      if (awf) begin
        check("awlen", 64'(awlen), 64'(0));
        check("awsize", 64'(awsize), 64'(2));
        check("awburst", 64'(awburst), 64'(1));
      end
      if (wf) begin
        check("wstrb", 64'(wstrb), 64'(4'hF));
        check("wlast", 64'(wlast), 64'(1));
      end
      if (reading) n_read++;
      if (writing) n_write++;
      exp_writing = 0;
      if (ready_wait > 0) ready_wait--;
      if (acc && stim_q.size() > 0) begin
        cur = stim_q.pop_front();
        exp_q.push_back({cur.addr, cur.data});
        outstanding = 1; aw_done = 0; w_done = 0; issue_age = 0;
        if (stim_q.size() > 0) offer_at = cycle + stim_q[0].gap;
      end else begin
        issue_age++;
      end
      if (awf) aw_done = 1;
      if (wf) w_done = 1;
      if (bf) begin
        outstanding = 0; exp_writing = 1; ready_wait = 1;
        if (cur.resp != 2'b00) begin
          resp_err_m = 1'b1;
          if (err_cnt_m != 16'hFFFF) err_cnt_m = err_cnt_m + 16'd1;
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (outstanding && aw_done && w_done) both_age++;
      else both_age = 0;
    end
    @(posedge clk);
    #1;
    areset = rst_req;
    if (stim_q.size() > 0 && cycle >= offer_at) begin
      tvalid = 1'b1; tdata = stim_q[0].data; write_buffer = stim_q[0].addr;
    end else begin
      tvalid = 1'b0; tdata = $urandom; write_buffer = $urandom;
    end
    awready = outstanding && !aw_done && issue_age >= cur.aw_dly;
    wready  = outstanding && !w_done && issue_age >= cur.w_dly;
    bvalid  = outstanding && aw_done && w_done && both_age >= 1 + cur.b_dly;
    bresp   = bvalid ? cur.resp : 2'($urandom);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((stim_q.size() > 0 || outstanding || exp_writing) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(stim_q.size() + int'(outstanding)), 64'(0));
    step();
  endtask

  initial begin
    int r0, w0, n;
    cur = '{default: 0};
    repeat (2) step();
    rst_req = 0;
    repeat (3) step();

    // single sample, zero-wait slave
    r0 = n_read; w0 = n_write;
    push(32'hA5A5_0001, 32'h1000_0000, 0, 0, 0, 2'b00, 0);
    drain(50);
    check("single_reads", 64'(n_read - r0), 64'(1));
    check("single_writes", 64'(n_write - w0), 64'(1));

    // AW and W complete in different cycles, both orders
    w0 = n_write;
    push(32'h0000_1111, 32'h1000_0040, 0, 3, 2, 2'b00, 0);
    push(32'h0000_2222, 32'h1000_0080, 3, 0, 1, 2'b00, 2);
    drain(80);
    check("split_writes", 64'(n_write - w0), 64'(2));

    // continuous tvalid, incrementing addresses
    r0 = n_read; w0 = n_write;
    for (int i = 0; i < 8; i++) push($urandom, 32'h2000_0000 + 32'(4 * i), 0, 0, 0, 2'b00, 0);
    drain(200);
    check("burst_reads", 64'(n_read - r0), 64'(8));
    check("burst_writes", 64'(n_write - w0), 64'(8));

    // SLVERR on the second of three writes
    w0 = n_write;
    push(32'h0000_0A01, 32'h3000_0000, 0, 0, 0, 2'b00, 0);
    push(32'h0000_0A02, 32'h3000_0004, 0, 0, 0, 2'b10, 0);
    push(32'h0000_0A03, 32'h3000_0008, 0, 0, 0, 2'b00, 0);
    drain(100);
    check("err_writes", 64'(n_write - w0), 64'(3));
    check("err_sticky", 64'(resp_error), 64'(1));
    check("err_count_one", 64'(error_count), 64'(1));

    // reset while AW/W are pending
    push(32'hDEAD_0005, 32'h4000_0000, 6, 6, 0, 2'b00, 0);
    n = 0;
    while (!outstanding && n < 50) begin step(); n++; end
    check("reset_test_accept", 64'(outstanding), 64'(1));
    w0 = n_write;
    rst_req = 1; step();
    rst_req = 0; step(); step(); step();
    check("reset_no_write", 64'(n_write - w0), 64'(0));
    check("reset_clears_err", 64'(error_count), 64'(0));
    push(32'hBEEF_0006, 32'h4000_0010, 1, 2, 1, 2'b00, 0);
    drain(60);
    check("after_reset_write", 64'(n_write - w0), 64'(1));

    // randomised traffic
    r0 = n_read; w0 = n_write;
    for (int i = 0; i < 60; i++)
      push($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, $urandom_range(0, 2));
    drain(3000);
    check("random_reads", 64'(n_read - r0), 64'(60));
    check("random_writes", 64'(n_write - w0), 64'(60));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
